// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: opcode patterns with don't-care masks, ALUOp classes,
// the ID-stage control bundle and the zero-register index.
package legv8_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_MOVZ = 11'b11010010100;

  localparam logic [10:0] MASK_EXACT = 11'b11111111111;
  localparam logic [10:0] MASK_CBZ   = 11'b11111111000;
  localparam logic [10:0] MASK_B     = 11'b11111100000;
  localparam logic [10:0] MASK_MOVZ  = 11'b11111111100;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_MOVZ   = 2'b11;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       uncondbranch;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_D    = 3'd1,
    IMM_CB   = 3'd2,
    IMM_B    = 3'd3,
    IMM_MOVZ = 3'd4
  } imm_kind_t;

  function automatic logic op_match(input logic [10:0] op, input logic [10:0] pat,
                                    input logic [10:0] mask);
    return ((op & mask) == pat);
  endfunction

endpackage

// File: rtl/instruction_decode_stage_register_file.sv
// LEGv8 register file: two async read ports, one write port, X31 reads as zero.
// Same-cycle write-to-read forwarding is enabled by REGFILE_WRITE_BYPASS_EN.
module register_file
  import legv8_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              resetl,
  input  logic [4:0]        raddr1,
  input  logic [4:0]        raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs_r [NREG];

  // Storage; writes aimed at XZR are dropped so entry 31 stays zero.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      for (int i = 0; i < NREG; i++) regs_r[i] <= '0;
    end else if (we && (waddr != XZR)) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Read port 1.
  always_comb begin
    rdata1 = '0;
    if (raddr1 == XZR) begin
      rdata1 = '0;
`ifdef REGFILE_WRITE_BYPASS_EN
    end else if (we && (raddr1 == waddr)) begin
      rdata1 = wdata;
`endif
    end else begin
      rdata1 = regs_r[raddr1];
    end
  end

  // Read port 2.
  always_comb begin
    rdata2 = '0;
    if (raddr2 == XZR) begin
      rdata2 = '0;
`ifdef REGFILE_WRITE_BYPASS_EN
    end else if (we && (raddr2 == waddr)) begin
      rdata2 = wdata;
`endif
    end else begin
      rdata2 = regs_r[raddr2];
    end
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// LEGv8 ID stage: control decode, register read, immediate extension, ID/EX register.
// Optional same-cycle WB->ID forwarding via REGFILE_WRITE_BYPASS_EN.
module instruction_decode_stage
  import legv8_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              resetl,
  input  logic [31:0]       instruction_ID,
  input  logic [63:0]       pc_ID,
  input  logic              flush_ID,
  input  logic              RegWrite_WB,
  input  logic [4:0]        WriteReg_WB,
  input  logic [DATA_W-1:0] WriteData_WB,
  output logic [63:0]       pc_EX,
  output logic [DATA_W-1:0] ReadData1_EX,
  output logic [DATA_W-1:0] ReadData2_EX,
  output logic [DATA_W-1:0] ExtImm_EX,
  output logic [4:0]        Rd_EX,
  output logic [10:0]       Opcode_EX,
  output logic              ALUSrc_EX,
  output logic              MemToReg_EX,
  output logic              RegWrite_EX,
  output logic              MemRead_EX,
  output logic              MemWrite_EX,
  output logic              Branch_EX,
  output logic              Uncondbranch_EX,
  output logic [1:0]        ALUOp_EX
);

  logic [10:0]       opcode_s;
  ctrl_t             ctrl_s;
  imm_kind_t         imm_kind_s;
  logic              reg2loc_s;
  logic [4:0]        raddr2_s;
  logic [DATA_W-1:0] rdata1_s;
  logic [DATA_W-1:0] rdata2_s;
  logic [DATA_W-1:0] ext_imm_s;

  assign opcode_s = instruction_ID[31:21];
  assign raddr2_s = reg2loc_s ? instruction_ID[4:0] : instruction_ID[20:16];

  // Main control decode; unknown opcodes fall through to an all-zero bubble.
  always_comb begin
    ctrl_s     = '0;
    imm_kind_s = IMM_NONE;
    reg2loc_s  = 1'b0;
    if (op_match(opcode_s, OP_ADD, MASK_EXACT) || op_match(opcode_s, OP_SUB, MASK_EXACT) ||
        op_match(opcode_s, OP_AND, MASK_EXACT) || op_match(opcode_s, OP_ORR, MASK_EXACT)) begin
      ctrl_s.reg_write = 1'b1;
      ctrl_s.alu_op    = ALUOP_RTYPE;
    end else if (op_match(opcode_s, OP_LDUR, MASK_EXACT)) begin
      ctrl_s.alu_src    = 1'b1;
      ctrl_s.mem_to_reg = 1'b1;
      ctrl_s.reg_write  = 1'b1;
      ctrl_s.mem_read   = 1'b1;
      ctrl_s.alu_op     = ALUOP_MEM;
      imm_kind_s        = IMM_D;
    end else if (op_match(opcode_s, OP_STUR, MASK_EXACT)) begin
      ctrl_s.alu_src   = 1'b1;
      ctrl_s.mem_write = 1'b1;
      ctrl_s.alu_op    = ALUOP_MEM;
      imm_kind_s       = IMM_D;
      reg2loc_s        = 1'b1;
    end else if (op_match(opcode_s, OP_CBZ, MASK_CBZ)) begin
      ctrl_s.branch = 1'b1;
      ctrl_s.alu_op = ALUOP_BRANCH;
      imm_kind_s    = IMM_CB;
      reg2loc_s     = 1'b1;
    end else if (op_match(opcode_s, OP_B, MASK_B)) begin
      ctrl_s.uncondbranch = 1'b1;
      imm_kind_s          = IMM_B;
    end else if (op_match(opcode_s, OP_MOVZ, MASK_MOVZ)) begin
      ctrl_s.alu_src   = 1'b1;
      ctrl_s.reg_write = 1'b1;
      ctrl_s.alu_op    = ALUOP_MOVZ;
      imm_kind_s       = IMM_MOVZ;
    end else begin
      ctrl_s = '0;
    end
  end

  // Immediate extension; MOVZ applies its hw shift here, other shifts happen in EX.
  always_comb begin
    ext_imm_s = '0;
    case (imm_kind_s)
      IMM_D:    ext_imm_s = {{(DATA_W-9){instruction_ID[20]}}, instruction_ID[20:12]};
      IMM_CB:   ext_imm_s = {{(DATA_W-19){instruction_ID[23]}}, instruction_ID[23:5]};
      IMM_B:    ext_imm_s = {{(DATA_W-26){instruction_ID[25]}}, instruction_ID[25:0]};
      IMM_MOVZ: ext_imm_s = DATA_W'(instruction_ID[20:5]) << {instruction_ID[22:21], 4'b0000};
      default:  ext_imm_s = '0;
    endcase
  end

  register_file #(.DATA_W(DATA_W), .NREG(NREG)) u_register_file (
    .clk    (clk),
    .resetl (resetl),
    .raddr1 (instruction_ID[9:5]),
    .raddr2 (raddr2_s),
    .rdata1 (rdata1_s),
    .rdata2 (rdata2_s),
    .we     (RegWrite_WB),
    .waddr  (WriteReg_WB),
    .wdata  (WriteData_WB)
  );

  // ID/EX pipeline register; a flush zeroes control only, data still advances.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      pc_EX           <= 64'd0;
      ReadData1_EX    <= '0;
      ReadData2_EX    <= '0;
      ExtImm_EX       <= '0;
      Rd_EX           <= 5'd0;
      Opcode_EX       <= 11'd0;
      ALUSrc_EX       <= 1'b0;
      MemToReg_EX     <= 1'b0;
      RegWrite_EX     <= 1'b0;
      MemRead_EX      <= 1'b0;
      MemWrite_EX     <= 1'b0;
      Branch_EX       <= 1'b0;
      Uncondbranch_EX <= 1'b0;
      ALUOp_EX        <= 2'b00;
    end else begin
      pc_EX           <= pc_ID;
      ReadData1_EX    <= rdata1_s;
      ReadData2_EX    <= rdata2_s;
      ExtImm_EX       <= ext_imm_s;
      Rd_EX           <= instruction_ID[4:0];
      Opcode_EX       <= opcode_s;
      ALUSrc_EX       <= ctrl_s.alu_src      & ~flush_ID;
      MemToReg_EX     <= ctrl_s.mem_to_reg   & ~flush_ID;
      RegWrite_EX     <= ctrl_s.reg_write    & ~flush_ID;
      MemRead_EX      <= ctrl_s.mem_read     & ~flush_ID;
      MemWrite_EX     <= ctrl_s.mem_write    & ~flush_ID;
      Branch_EX       <= ctrl_s.branch       & ~flush_ID;
      Uncondbranch_EX <= ctrl_s.uncondbranch & ~flush_ID;
      ALUOp_EX        <= flush_ID ? 2'b00 : ctrl_s.alu_op;
    end
  end

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed bench for instruction_decode_stage: mnemonic-level reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_instruction_decode_stage;

  logic        clk;
  logic        resetl;
  logic [31:0] instruction_ID;
  logic [63:0] pc_ID;
  logic        flush_ID;
  logic        RegWrite_WB;
  logic [4:0]  WriteReg_WB;
  logic [63:0] WriteData_WB;
  logic [63:0] pc_EX, ReadData1_EX, ReadData2_EX, ExtImm_EX;
  logic [4:0]  Rd_EX;
  logic [10:0] Opcode_EX;
  logic        ALUSrc_EX, MemToReg_EX, RegWrite_EX, MemRead_EX, MemWrite_EX;
  logic        Branch_EX, Uncondbranch_EX;
  logic [1:0]  ALUOp_EX;

  int vectors = 0;
  int miscompares = 0;

  instruction_decode_stage dut (
    .clk(clk), .resetl(resetl), .instruction_ID(instruction_ID), .pc_ID(pc_ID),
    .flush_ID(flush_ID), .RegWrite_WB(RegWrite_WB), .WriteReg_WB(WriteReg_WB),
    .WriteData_WB(WriteData_WB), .pc_EX(pc_EX), .ReadData1_EX(ReadData1_EX),
    .ReadData2_EX(ReadData2_EX), .ExtImm_EX(ExtImm_EX), .Rd_EX(Rd_EX),
    .Opcode_EX(Opcode_EX), .ALUSrc_EX(ALUSrc_EX), .MemToReg_EX(MemToReg_EX),
    .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
    .Branch_EX(Branch_EX), .Uncondbranch_EX(Uncondbranch_EX), .ALUOp_EX(ALUOp_EX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc, rd1, rd2, imm;
    logic [4:0]  rd;
    logic [10:0] opc;
    logic alusrc, memtoreg, regwrite, memread, memwrite, branch, uncond;
    logic [1:0]  aluop;
  } exp_t;

  logic [63:0] mregs [32];
  exp_t        expv;
  bit          exp_valid = 1'b0;

  function automatic logic [63:0] mread(input logic [4:0] a);
    if (a == 5'd31) return 64'd0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (RegWrite_WB && a == WriteReg_WB) return WriteData_WB;
`endif
    return mregs[a];
  endfunction

  // What ID/EX must hold after an edge that sees this instruction.
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc, input bit flush);
    exp_t e;
    logic [4:0] src2;
    e = '{default: '0};
    e.pc = pc; e.rd = ins[4:0]; e.opc = ins[31:21];
    src2 = ins[20:16];
    casez (ins[31:21])
      11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: begin
        e.regwrite = 1; e.aluop = 2'd2;
      end
      11'b11111000010: begin
        e.alusrc = 1; e.memtoreg = 1; e.regwrite = 1; e.memread = 1;
        e.imm = longint'($signed(ins[20:12]));
      end
      11'b11111000000: begin
        e.alusrc = 1; e.memwrite = 1; src2 = ins[4:0];
        e.imm = longint'($signed(ins[20:12]));
      end
      11'b10110100???: begin
        e.branch = 1; e.aluop = 2'd1; src2 = ins[4:0];
        e.imm = longint'($signed(ins[23:5]));
      end
      11'b000101?????: begin
        e.uncond = 1; e.imm = longint'($signed(ins[25:0]));
      end
      11'b110100101??: begin
        e.alusrc = 1; e.regwrite = 1; e.aluop = 2'd3;
        e.imm = 64'(ins[20:5]) * (64'd1 << (16 * int'(ins[22:21])));
      end
      default: ;
    endcase
    e.rd1 = mread(ins[9:5]);
    e.rd2 = mread(src2);
    if (flush) begin
      e.alusrc = 0; e.memtoreg = 0; e.regwrite = 0; e.memread = 0;
      e.memwrite = 0; e.branch = 0; e.uncond = 0; e.aluop = 2'd0;
    end
    return e;
  endfunction

  always @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
      exp_valid = 1'b0;
    end else begin
      expv = model(instruction_ID, pc_ID, flush_ID);
      if (RegWrite_WB && WriteReg_WB != 5'd31) mregs[WriteReg_WB] = WriteData_WB;
      exp_valid = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (resetl && exp_valid) begin
      chk("m.pc", pc_EX, expv.pc);
      chk("m.rd1", ReadData1_EX, expv.rd1);
      chk("m.rd2", ReadData2_EX, expv.rd2);
      chk("m.imm", ExtImm_EX, expv.imm);
      chk("m.rd", 64'(Rd_EX), 64'(expv.rd));
      chk("m.opc", 64'(Opcode_EX), 64'(expv.opc));
      chk("m.alusrc", 64'(ALUSrc_EX), 64'(expv.alusrc));
      chk("m.memtoreg", 64'(MemToReg_EX), 64'(expv.memtoreg));
      chk("m.regwrite", 64'(RegWrite_EX), 64'(expv.regwrite));
      chk("m.memread", 64'(MemRead_EX), 64'(expv.memread));
      chk("m.memwrite", 64'(MemWrite_EX), 64'(expv.memwrite));
      chk("m.branch", 64'(Branch_EX), 64'(expv.branch));
      chk("m.uncond", 64'(Uncondbranch_EX), 64'(expv.uncond));
      chk("m.aluop", 64'(ALUOp_EX), 64'(expv.aluop));
    end
  end

  // Called at a negedge: drive, let one rising edge pass, return at the next negedge.
  task automatic apply(input logic [31:0] ins, input logic [63:0] pc, input bit fl,
                       input bit we, input logic [4:0] wr, input logic [63:0] wd);
    instruction_ID = ins; pc_ID = pc; flush_ID = fl;
    RegWrite_WB = we; WriteReg_WB = wr; WriteData_WB = wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pc"}, pc_EX, 64'd0);
    chk({tag, ".rd1"}, ReadData1_EX, 64'd0);
    chk({tag, ".rd2"}, ReadData2_EX, 64'd0);
    chk({tag, ".imm"}, ExtImm_EX, 64'd0);
    chk({tag, ".rd"}, 64'(Rd_EX), 64'd0);
    chk({tag, ".opc"}, 64'(Opcode_EX), 64'd0);
    chk({tag, ".ctrl"}, 64'({ALUSrc_EX, MemToReg_EX, RegWrite_EX, MemRead_EX, MemWrite_EX,
                             Branch_EX, Uncondbranch_EX, ALUOp_EX}), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetl = 1'b0;
    instruction_ID = 32'd0; pc_ID = 64'd0; flush_ID = 1'b0;
    RegWrite_WB = 1'b0; WriteReg_WB = 5'd0; WriteData_WB = 64'd0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    resetl = 1'b1;

    apply(32'd0, 64'h0F0, 1'b0, 1'b1, 5'd1, 64'd5);
    apply(32'd0, 64'h0F4, 1'b0, 1'b1, 5'd2, 64'd7);

    // ADD X3,X1,X2
    apply(32'h8B020023, 64'h100, 1'b0, 1'b0, 5'd0, 64'd0);
    chk("add.rd1", ReadData1_EX, 64'd5);
    chk("add.rd2", ReadData2_EX, 64'd7);
    chk("add.rd", 64'(Rd_EX), 64'd3);
    chk("add.regwrite", 64'(RegWrite_EX), 64'd1);
    chk("add.aluop", 64'(ALUOp_EX), 64'd2);
    chk("add.alusrc", 64'(ALUSrc_EX), 64'd0);
    chk("add.pc", pc_EX, 64'h100);

    // LDUR X4,[X1,#-8]
    apply(32'hF85F8024, 64'h104, 1'b0, 1'b0, 5'd0, 64'd0);
    chk("ldur.imm", ExtImm_EX, 64'hFFFFFFFFFFFFFFF8);
    chk("ldur.memread", 64'(MemRead_EX), 64'd1);
    chk("ldur.memtoreg", 64'(MemToReg_EX), 64'd1);
    chk("ldur.alusrc", 64'(ALUSrc_EX), 64'd1);

    // STUR X2,[X1,#0]
    apply(32'hF8000022, 64'h108, 1'b0, 1'b0, 5'd0, 64'd0);
    chk("stur.rd2", ReadData2_EX, 64'd7);
    chk("stur.memwrite", 64'(MemWrite_EX), 64'd1);
    chk("stur.regwrite", 64'(RegWrite_EX), 64'd0);

    // CBZ X2,#-1 flushed, then live
    apply(32'hB4FFFFE2, 64'h10C, 1'b1, 1'b0, 5'd0, 64'd0);
    chk("cbzf.ctrl", 64'({ALUSrc_EX, MemToReg_EX, RegWrite_EX, MemRead_EX, MemWrite_EX,
                          Branch_EX, Uncondbranch_EX, ALUOp_EX}), 64'd0);
    chk("cbzf.pc", pc_EX, 64'h10C);
    apply(32'hB4FFFFE2, 64'h110, 1'b0, 1'b0, 5'd0, 64'd0);
    chk("cbz.branch", 64'(Branch_EX), 64'd1);
    chk("cbz.imm", ExtImm_EX, 64'hFFFFFFFFFFFFFFFF);
    chk("cbz.aluop", 64'(ALUOp_EX), 64'd1);

    // MOVZ X8,#0x1234,LSL 16 and B #3
    apply(32'hD2A24688, 64'h114, 1'b0, 1'b0, 5'd0, 64'd0);
    chk("movz.imm", ExtImm_EX, 64'h0000000012340000);
    chk("movz.aluop", 64'(ALUOp_EX), 64'd3);
    apply(32'h14000003, 64'h118, 1'b0, 1'b0, 5'd0, 64'd0);
    chk("b.uncond", 64'(Uncondbranch_EX), 64'd1);
    chk("b.imm", ExtImm_EX, 64'd3);

    // Unknown opcode is a bubble
    apply(32'hFFFFFFFF, 64'h11C, 1'b0, 1'b0, 5'd0, 64'd0);
    chk("bubble.ctrl", 64'({ALUSrc_EX, MemToReg_EX, RegWrite_EX, MemRead_EX, MemWrite_EX,
                            Branch_EX, Uncondbranch_EX, ALUOp_EX}), 64'd0);
    chk("bubble.imm", ExtImm_EX, 64'd0);

    // WB writes X5 while ID reads X5 (ADD X6,X5,X0)
    apply(32'd0, 64'h120, 1'b0, 1'b1, 5'd5, 64'h1111);
    apply(32'h8B0000A6, 64'h124, 1'b0, 1'b1, 5'd5, 64'hABCD);
`ifdef REGFILE_WRITE_BYPASS_EN
    chk("byp.rd1", ReadData1_EX, 64'hABCD);
`else
    chk("byp.rd1", ReadData1_EX, 64'h1111);
`endif
    apply(32'h8B0000A6, 64'h128, 1'b0, 1'b0, 5'd0, 64'd0);
    chk("byp.after", ReadData1_EX, 64'hABCD);

    // X31 discards writes and reads zero (ADD X7,XZR,XZR)
    apply(32'd0, 64'h12C, 1'b0, 1'b1, 5'd31, 64'd9);
    apply(32'h8B1F03E7, 64'h130, 1'b0, 1'b0, 5'd0, 64'd0);
    chk("xzr.rd1", ReadData1_EX, 64'd0);
    chk("xzr.rd2", ReadData2_EX, 64'd0);

    // Asynchronous reset mid-stream, then register file must be cleared
    apply(32'h8B020023, 64'h134, 1'b0, 1'b0, 5'd0, 64'd0);
    #1 resetl = 1'b0;
    #1 chk_all_zero("areset");
    @(negedge clk);
    resetl = 1'b1;
    apply(32'h8B020023, 64'h138, 1'b0, 1'b0, 5'd0, 64'd0);
    chk("postrst.rd1", ReadData1_EX, 64'd0);
    chk("postrst.rd2", ReadData2_EX, 64'd0);
    chk("postrst.regwrite", 64'(RegWrite_EX), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
